// File: rtl/matmul_scheduler_if.sv
// matmul_scheduler_if
//   Bundles the control handshake and operand/result memory ports of the
//   matrix-multiply scheduler.
//   slave  : the scheduler side (drives status, read strobe/addresses, writes)
//   master : the control/memory side (drives start, size, operand data)
//   Signals: start, matrix_size, busy, done, err, rd_en, addr_a, addr_b,
//            a_data, b_data, res_we, res_addr, res_data.
interface matmul_scheduler_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [3:0]        matrix_size;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [7:0]        a_data;
    logic [7:0]        b_data;
    logic              res_we;
    logic [ADDR_W-1:0] res_addr;
    logic [15:0]       res_data;

    modport slave (
        input  start, matrix_size, a_data, b_data,
        output busy, done, err, rd_en, addr_a, addr_b, res_we, res_addr, res_data
    );

    modport master (
        output start, matrix_size, a_data, b_data,
        input  busy, done, err, rd_en, addr_a, addr_b, res_we, res_addr, res_data
    );
endinterface

// File: rtl/matmul_scheduler.sv
// matmul_scheduler
//   Walks the (i, j, k) loop nest of one NxN unsigned 8-bit matrix multiply,
//   issuing row-major reads to the A/B buffers (1-cycle synchronous RAM),
//   accumulating products into 16-bit sums and writing each result element.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - matmul_scheduler_if.slave (handshake + memory ports)
module matmul_scheduler #(
    parameter int MAX_N  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    matmul_scheduler_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_n, r_i, r_j, r_k;
    logic        w_k_last, w_j_last, w_i_last;
    logic        w_size_ok, w_accept;
    logic [7:0]  w_i_base, w_k_base;

    // one-stage pipeline matching the RAM read latency
    logic        r_p_vld, r_p_first, r_p_last;
    logic [ADDR_W-1:0] r_p_addr;

    logic [15:0] r_acc, w_prod, w_sum;
    logic        r_res_we, r_done, r_err;
    logic [ADDR_W-1:0] r_res_addr;
    logic [15:0] r_res_data;

    assign w_k_last  = (r_k == r_n - 4'd1);
    assign w_j_last  = (r_j == r_n - 4'd1);
    assign w_i_last  = (r_i == r_n - 4'd1);
    assign w_size_ok = (bus.matrix_size != 4'd0) && (bus.matrix_size <= 4'(MAX_N));
    assign w_accept  = (r_state == S_IDLE) && bus.start && w_size_ok;

    assign w_i_base = {4'b0, r_i} * {4'b0, r_n};
    assign w_k_base = {4'b0, r_k} * {4'b0, r_n};

    assign w_prod = {8'b0, bus.a_data} * {8'b0, bus.b_data};
    assign w_sum  = (r_p_first ? 16'd0 : r_acc) + w_prod;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_k_last && w_j_last && w_i_last) w_next = S_DRAIN;
            // hold through the done cycle so busy drops only after done
            S_DRAIN: if (r_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n <= '0;
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (w_accept) begin
            r_n <= bus.matrix_size;
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (r_state == S_RUN) begin
            if (w_k_last) begin
                r_k <= '0;
                if (w_j_last) begin
                    r_j <= '0;
                    r_i <= w_i_last ? 4'd0 : r_i + 4'd1;
                end else begin
                    r_j <= r_j + 4'd1;
                end
            end else begin
                r_k <= r_k + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_vld    <= 1'b0;
            r_p_first  <= 1'b0;
            r_p_last   <= 1'b0;
            r_p_addr   <= '0;
            r_acc      <= '0;
            r_res_we   <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_p_vld   <= (r_state == S_RUN);
            r_p_first <= (r_k == 4'd0);
            r_p_last  <= w_k_last;
            r_p_addr  <= ADDR_W'(w_i_base + {4'b0, r_j});
            if (r_p_vld) r_acc <= w_sum;
            r_res_we <= r_p_vld && r_p_last;
            if (r_p_vld && r_p_last) begin
                r_res_data <= w_sum;
                r_res_addr <= r_p_addr;
            end
            // the only write seen in DRAIN is the final one
            r_done <= (r_state == S_DRAIN) && r_res_we && !r_done;
            r_err  <= (r_state == S_IDLE) && bus.start && !w_size_ok;
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.rd_en    = (r_state == S_RUN);
    assign bus.addr_a   = ADDR_W'(w_i_base + {4'b0, r_k});
    assign bus.addr_b   = ADDR_W'(w_k_base + {4'b0, r_j});
    assign bus.res_we   = r_res_we;
    assign bus.res_addr = r_res_addr;
    assign bus.res_data = r_res_data;
endmodule

// File: doc/matmul_scheduler.md
# matmul_scheduler

Sequences one N×N matrix multiply over the matrix-A and matrix-B buffers once both are loaded. It walks the (i, j, k) loop nest, issues row-major read addresses to both buffers, and accumulates the unsigned 8-bit products. It writes each 16-bit result element to the result buffer and signals completion. It sits between the top-level control unit's mult_start/mult_done handshake and the operand/result memories.

## Interface
- MAX_N, 8: largest accepted matrix dimension; legal range 1..15.
- ADDR_W, 6: buffer address width; must satisfy 2^ADDR_W ≥ MAX_N².
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a multiply; sampled only in IDLE.
- matrix_size  in  4  N; sampled together with start.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse after the final result write.
- err  out  1  one-cycle pulse when start arrives with an illegal size.
- rd_en  out  1  read strobe to both operand buffers.
- addr_a  out  ADDR_W  A read address, i*N+k.
- addr_b  out  ADDR_W  B read address, k*N+j.
- a_data  in  8  A element; valid the cycle after rd_en (synchronous RAM).
- b_data  in  8  B element; valid the cycle after rd_en.
- res_we  out  1  result write strobe.
- res_addr  out  ADDR_W  result address, i*N+j.
- res_data  out  16  result element.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start with 1 ≤ matrix_size ≤ MAX_N: latch N; clear i, j, k; go to RUN.
  - start with matrix_size 0 or > MAX_N: pulse err for one cycle; remain in IDLE.
- RUN:
  - rd_en = 1 every cycle, with addr_a/addr_b computed from the current (i, j, k).
  - Loop order: k increments fastest, then j, then i. Each counter wraps to 0 at N-1 and carries into the next.
  - Each issue registers first = (k == 0), last = (k == N-1) and the result address i*N+j into a 1-stage pipeline alongside the RAM latency.
  - On the issue with i = j = k = N-1, go to DRAIN.
- Data-return cycle (pipeline valid):
  - sum = (first ? 0 : acc) + a_data*b_data; acc <= sum.
  - If last: register res_data <= sum, res_addr <= pipelined address, res_we <= 1 for the following cycle.
- DRAIN: wait for the final res_we, then pulse done the next cycle and return to IDLE.
- Arithmetic is unsigned. The product is 16 bits; acc and res_data are 16 bits and wrap modulo 2^16, with no saturation and no overflow flag.
- Results are written in order 0 .. N²-1, each address exactly once.
- start while busy is ignored (no err, no restart).
- rd_en is never asserted outside RUN; res_we is never asserted outside the cycle after a last-k data return.

## Timing
- Reset: every output = 0, state = IDLE, counters and acc = 0. Reset takes effect immediately and asynchronously.
- Reset mid-operation: abort the multiply with no further rd_en/res_we; no done pulse; the next start after release is accepted normally.
- Call the edge that samples start E0.
  - busy rises after E0 and falls after done deasserts.
  - rd_en is high for exactly N³ consecutive cycles, following E0 .. E(N³)-1.
  - Final res_we is the cycle after E(N³+1).
  - done is the cycle after E(N³+2).
  - Total latency from start to done: N³+3 cycles.
- Result element (i, j) is written 2 cycles after its k = N-1 issue cycle.
- err asserts the cycle after the sampling edge; busy stays 0.
- Back-to-back operation: start is accepted in the cycle after done.

## Test plan
- N=2, A=[1,2;3,4], B=[5,6;7,8] -> res_we at addresses 0,1,2,3 with data 19,22,43,50; rd_en high 8 cycles; done 11 cycles after start.
- N=1, A=[7], B=[9] -> one rd_en cycle, addr_a = addr_b = 0; res_we addr 0 data 63; done 4 cycles after start.
- N=3, all elements 255 -> nine writes, each 64003 (195075 mod 65536).
- matrix_size=0, then matrix_size=9 with MAX_N=8 -> err pulse each time; busy, rd_en, res_we stay 0.
- N=3 run; start pulsed with matrix_size=2 mid-run -> ignored; exactly 9 writes; done after 30 cycles.
- N=3 run; rst low at cycle 10 -> all outputs 0 immediately; no done; subsequent N=2 run produces the correct results.
